// File: rtl/spc7110_pkg.sv
// Shared definitions for the SPC7110 data port and the address generator it shares with the DCU.
package spc7110_pkg;
  localparam logic [3:0] DP_DATA  = 4'h0;
  localparam logic [3:0] DP_BASE0 = 4'h1;
  localparam logic [3:0] DP_BASE1 = 4'h2;
  localparam logic [3:0] DP_BASE2 = 4'h3;
  localparam logic [3:0] DP_ADJ0  = 4'h4;
  localparam logic [3:0] DP_ADJ1  = 4'h5;
  localparam logic [3:0] DP_STEP0 = 4'h6;
  localparam logic [3:0] DP_STEP1 = 4'h7;
  localparam logic [3:0] DP_MODE  = 4'h8;

  localparam int MODE_STEP   = 0;
  localparam int MODE_ADJ    = 1;
  localparam int MODE_SSTEP  = 2;
  localparam int MODE_SADJ   = 3;
  localparam int MODE_ADJINC = 4;

  typedef enum logic {DP_IDLE, DP_REQ} dp_state_e;

  function automatic logic [23:0] ext16(input logic [15:0] v, input logic sgn);
    return sgn ? {{8{v[15]}}, v} : {8'h00, v};
  endfunction
endpackage

// File: rtl/spc7110_dataport_if.sv
// SNES register window plus data-ROM request channel of the SPC7110 data port.
interface spc7110_dataport_if #(parameter int REG_W = 8);
  logic             dp_enable;
  logic [3:0]       reg_addr;
  logic             reg_we;
  logic             reg_re;
  logic [REG_W-1:0] reg_wdata;
  logic [REG_W-1:0] reg_rdata;
  logic [23:0]      ROM_MASK;
  logic             rom_req;
  logic [23:0]      rom_addr;
  logic             rom_ack;
  logic [REG_W-1:0] rom_data;
  logic             buf_valid;

  modport slave (
    input  dp_enable, reg_addr, reg_we, reg_re, reg_wdata, ROM_MASK, rom_ack, rom_data,
    output reg_rdata, rom_req, rom_addr, buf_valid
  );
  modport master (
    output dp_enable, reg_addr, reg_we, reg_re, reg_wdata, ROM_MASK, rom_ack, rom_data,
    input  reg_rdata, rom_req, rom_addr, buf_valid
  );
endinterface

// File: rtl/spc7110_dp_addrgen.sv
// Combinational pointer math: increment and masked SRAM0 fetch address.
module spc7110_dp_addrgen
  import spc7110_pkg::*;
#(
  parameter logic [23:0] DROM_BASE = 24'h100000
) (
  input  logic [23:0] base,
  input  logic [15:0] adjust,
  input  logic [15:0] step,
  input  logic [4:0]  mode,
  input  logic [23:0] rom_mask,
  output logic [23:0] inc,
  output logic [23:0] rom_addr
);
  logic [23:0] eff;

  // Kept as separate assigns: inc depends only on step/mode, which lets the
  // parent feed next-state registers in without a combinational loop.
  assign inc      = mode[MODE_STEP] ? ext16(step, mode[MODE_SSTEP]) : 24'd1;
  assign eff      = base + (mode[MODE_ADJ] ? ext16(adjust, mode[MODE_SADJ]) : 24'd0);
  assign rom_addr = DROM_BASE + (eff & rom_mask);
endmodule

// File: rtl/spc7110_dataport.sv
// SPC7110 $4810-$4818 data port: pointer registers, one-byte prefetch and ROM fetch FSM.
module spc7110_dataport
  import spc7110_pkg::*;
#(
  parameter logic [23:0] DROM_BASE = 24'h100000,
  parameter int          REG_W     = 8
) (
  input logic                CLK,
  input logic                RST_N,
  spc7110_dataport_if.slave  bus
);
  logic [23:0]      base, base_n, inc, addr_n, addr_q;
  logic [15:0]      adjust, adjust_n, step, step_n;
  logic [4:0]       mode, mode_n;
  logic [REG_W-1:0] buffer, rd_mux;
  logic             refetch, refetch_n, latch, load, trig, we, re, bv;
  dp_state_e        state, state_n;

  assign we   = bus.dp_enable & bus.reg_we;
  assign re   = bus.dp_enable & bus.reg_re;
  assign trig = (we && bus.reg_addr >= DP_BASE0 && bus.reg_addr <= DP_MODE) ||
                (re && bus.reg_addr == DP_DATA);

  always_comb begin
    step_n = step;
    mode_n = mode;
    if (we) begin
      case (bus.reg_addr)
        DP_STEP0: step_n[7:0]  = bus.reg_wdata[7:0];
        DP_STEP1: step_n[15:8] = bus.reg_wdata[7:0];
        DP_MODE:  mode_n       = bus.reg_wdata[4:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    base_n   = base;
    adjust_n = adjust;
    if (we) begin
      case (bus.reg_addr)
        DP_BASE0: base_n[7:0]    = bus.reg_wdata[7:0];
        DP_BASE1: base_n[15:8]   = bus.reg_wdata[7:0];
        DP_BASE2: base_n[23:16]  = bus.reg_wdata[7:0];
        DP_ADJ0:  adjust_n[7:0]  = bus.reg_wdata[7:0];
        DP_ADJ1:  adjust_n[15:8] = bus.reg_wdata[7:0];
        default: ;
      endcase
    end else if (re && bus.reg_addr == DP_DATA) begin
      if (mode[MODE_ADJINC]) adjust_n = adjust + inc[15:0];
      else                   base_n   = base + inc;
    end
  end

  // Fed with next-state registers so a fetch latched on the trigger edge
  // already sees the write or post-increment of that same cycle.
  spc7110_dp_addrgen #(.DROM_BASE(DROM_BASE)) u_addrgen (
    .base(base_n), .adjust(adjust_n), .step(step_n), .mode(mode_n),
    .rom_mask(bus.ROM_MASK), .inc(inc), .rom_addr(addr_n)
  );

  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr)
      DP_DATA:  rd_mux      = buffer;
      DP_BASE0: rd_mux[7:0] = base[7:0];
      DP_BASE1: rd_mux[7:0] = base[15:8];
      DP_BASE2: rd_mux[7:0] = base[23:16];
      DP_ADJ0:  rd_mux[7:0] = adjust[7:0];
      DP_ADJ1:  rd_mux[7:0] = adjust[15:8];
      DP_STEP0: rd_mux[7:0] = step[7:0];
      DP_STEP1: rd_mux[7:0] = step[15:8];
      DP_MODE:  rd_mux[7:0] = {3'b000, mode};
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state;
    refetch_n = refetch;
    latch     = 1'b0;
    load      = 1'b0;
    case (state)
      DP_IDLE: if (trig) begin
        state_n = DP_REQ;
        latch   = 1'b1;
      end
      DP_REQ: begin
        if (bus.rom_ack) begin
          // Data answering a stale address is dropped and the fetch reissued.
          if (refetch || trig) begin
            refetch_n = 1'b0;
            latch     = 1'b1;
          end else begin
            load    = 1'b1;
            state_n = DP_IDLE;
          end
        end else if (trig) begin
          refetch_n = 1'b1;
        end
      end
      default: state_n = DP_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= DP_IDLE;
      refetch       <= 1'b0;
      addr_q        <= '0;
      buffer        <= '0;
      bv            <= 1'b0;
      base          <= '0;
      adjust        <= '0;
      step          <= '0;
      mode          <= '0;
      bus.reg_rdata <= '0;
    end else begin
      state   <= state_n;
      refetch <= refetch_n;
      base    <= base_n;
      adjust  <= adjust_n;
      step    <= step_n;
      mode    <= mode_n;
      if (latch) addr_q <= addr_n;
      if (load)  buffer <= bus.rom_data;
      if (trig)      bv <= 1'b0;
      else if (load) bv <= 1'b1;
      if (re) bus.reg_rdata <= rd_mux;
    end
  end

  assign bus.rom_req   = (state == DP_REQ);
  assign bus.rom_addr  = addr_q;
  assign bus.buf_valid = bv;
endmodule

// File: tb/tb_spc7110_dataport.sv
// Scoreboard bench for spc7110_dataport: stimulus queues expectations, a monitor checks outputs.
module tb_spc7110_dataport;
  localparam logic [23:0] MASK = 24'h3FFFFF;

  logic clk = 1'b0;
  logic RST_N = 1'b0;
  logic st_chk = 1'b0;
  logic done = 1'b0;
  logic rd_pend = 1'b0;
  int   nvec = 0;
  int   nmiss = 0;

  logic [7:0]  q_rd[$];
  logic [23:0] q_ack[$];
  logic [1:0]  q_st[$];

  spc7110_dataport_if bus();

  spc7110_dataport dut (.CLK(clk), .RST_N(RST_N), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [7:0]  er;
    logic [23:0] ea;
    logic [1:0]  es;
    if (rd_pend) begin
      nvec++;
      if (q_rd.size() == 0) begin
        nmiss++; $display("FAIL rdata: unexpected read result %h", bus.reg_rdata);
      end else begin
        er = q_rd.pop_front();
        if (bus.reg_rdata !== er) begin
          nmiss++; $display("FAIL rdata: got %h want %h at %0t", bus.reg_rdata, er, $time);
        end
      end
    end
    rd_pend = bus.reg_re & bus.dp_enable & RST_N;
    if (bus.rom_ack && bus.rom_req) begin
      nvec++;
      if (q_ack.size() == 0) begin
        nmiss++; $display("FAIL rom_addr: unexpected request at %h", bus.rom_addr);
      end else begin
        ea = q_ack.pop_front();
        if (bus.rom_addr !== ea) begin
          nmiss++; $display("FAIL rom_addr: got %h want %h at %0t", bus.rom_addr, ea, $time);
        end
      end
    end
    if (st_chk) begin
      nvec++;
      es = (q_st.size() != 0) ? q_st.pop_front() : 2'bxx;
      if ({bus.rom_req, bus.buf_valid} !== es) begin
        nmiss++; $display("FAIL status: req/bv got %b want %b at %0t", {bus.rom_req, bus.buf_valid}, es, $time);
      end
    end
    if (done) begin
      if (q_rd.size() + q_ack.size() + q_st.size() != 0) begin
        nmiss++; $display("FAIL leftover: %0d expectations never matched, want 0",
                          q_rd.size() + q_ack.size() + q_st.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic en, input logic [3:0] a, input logic [7:0] d);
    bus.dp_enable = en; bus.reg_addr = a; bus.reg_wdata = d; bus.reg_we = 1'b1;
    tick();
    bus.reg_we = 1'b0; bus.dp_enable = 1'b0;
  endtask

  task automatic rd(input logic en, input logic [3:0] a, input logic [7:0] e);
    if (en) q_rd.push_back(e);
    bus.dp_enable = en; bus.reg_addr = a; bus.reg_re = 1'b1;
    tick();
    bus.reg_re = 1'b0; bus.dp_enable = 1'b0;
  endtask

  task automatic ack(input logic [7:0] d, input logic [23:0] ea);
    q_ack.push_back(ea);
    bus.rom_ack = 1'b1; bus.rom_data = d;
    tick();
    bus.rom_ack = 1'b0;
  endtask

  task automatic ackwr(input logic [7:0] d, input logic [23:0] ea, input logic [3:0] a, input logic [7:0] wd);
    q_ack.push_back(ea);
    bus.rom_ack = 1'b1; bus.rom_data = d;
    bus.dp_enable = 1'b1; bus.reg_addr = a; bus.reg_wdata = wd; bus.reg_we = 1'b1;
    tick();
    bus.rom_ack = 1'b0; bus.reg_we = 1'b0; bus.dp_enable = 1'b0;
  endtask

  task automatic st(input logic req, input logic bv);
    q_st.push_back({req, bv});
    st_chk = 1'b1;
    tick();
    st_chk = 1'b0;
  endtask

  initial begin
    bus.dp_enable = 0; bus.reg_addr = 0; bus.reg_we = 0; bus.reg_re = 0;
    bus.reg_wdata = 0; bus.rom_ack = 0; bus.rom_data = 0; bus.ROM_MASK = MASK;
    tick(); tick();
    st(0, 0);
    RST_N = 1'b1;
    tick();
    rd(1, 4'h1, 8'h00); rd(1, 4'h3, 8'h00); rd(1, 4'h8, 8'h00);

    // reset in the middle of a request; late ack must be ignored
    wr(1, 4'h1, 8'h55);
    st(1, 0);
    RST_N = 1'b0;
    st(0, 0);
    RST_N = 1'b1;
    bus.rom_ack = 1'b1; bus.rom_data = 8'h77; tick(); bus.rom_ack = 1'b0;
    st(0, 0);
    rd(1, 4'h1, 8'h00);
    rd(1, 4'h0, 8'h00);
    ack(8'h11, 24'h100001);
    st(0, 1);

    // basic prefetch
    wr(1, 4'h8, 8'h00);
    wr(1, 4'h1, 8'h56); wr(1, 4'h2, 8'h34); wr(1, 4'h3, 8'h12);
    ack(8'h00, 24'h100001);
    tick(); tick();
    st(1, 0);
    ack(8'hA5, 24'h223456);
    st(0, 1);
    rd(1, 4'h0, 8'hA5);
    ack(8'h5A, 24'h223457);
    rd(1, 4'h1, 8'h57); rd(1, 4'h3, 8'h12);

    // sign-extended step, including wrap below zero
    wr(1, 4'h6, 8'hFE); wr(1, 4'h7, 8'hFF); wr(1, 4'h8, 8'h05);
    wr(1, 4'h1, 8'h10); wr(1, 4'h2, 8'h00); wr(1, 4'h3, 8'h00);
    ack(8'h00, 24'h223457);
    ack(8'hC3, 24'h100010);
    rd(1, 4'h0, 8'hC3);
    ack(8'h3C, 24'h10000E);
    rd(1, 4'h1, 8'h0E);
    wr(1, 4'h1, 8'h00);
    ack(8'h96, 24'h100000);
    rd(1, 4'h0, 8'h96);
    ack(8'h69, 24'h4FFFFE);
    rd(1, 4'h1, 8'hFE); rd(1, 4'h2, 8'hFF); rd(1, 4'h3, 8'hFF);

    // adjust in address and post-increment of adjust
    wr(1, 4'h8, 8'h1B);
    wr(1, 4'h4, 8'hFF); wr(1, 4'h5, 8'hFF); wr(1, 4'h6, 8'h01); wr(1, 4'h7, 8'h00);
    wr(1, 4'h1, 8'h00); wr(1, 4'h2, 8'h10); wr(1, 4'h3, 8'h00);
    ack(8'h00, 24'h4FFFFE);
    ack(8'hD7, 24'h100FFF);
    rd(1, 4'h0, 8'hD7);
    ack(8'h7D, 24'h101000);
    rd(1, 4'h4, 8'h00); rd(1, 4'h5, 8'h00); rd(1, 4'h1, 8'h00); rd(1, 4'h2, 8'h10);

    // collisions: write during request, then write and ack together
    wr(1, 4'h8, 8'h00);
    ack(8'h11, 24'h101000);
    rd(1, 4'h0, 8'h11);
    tick();
    wr(1, 4'h1, 8'h80);
    tick();
    ack(8'hEE, 24'h101001);
    ack(8'h22, 24'h101080);
    rd(1, 4'h0, 8'h22);
    ackwr(8'hEE, 24'h101081, 4'h1, 8'h40);
    ack(8'h33, 24'h101040);
    rd(1, 4'h0, 8'h33);
    ack(8'h44, 24'h101041);
    st(0, 1);

    // readback masking, unmapped registers, disabled strobes
    wr(1, 4'h8, 8'hFF);
    ack(8'h55, 24'h101041);
    rd(1, 4'h8, 8'h1F);
    rd(1, 4'hC, 8'h00);
    wr(0, 4'h1, 8'hAA);
    rd(0, 4'h0, 8'h00);
    wr(1, 4'h0, 8'h99);
    wr(1, 4'h9, 8'h77);
    st(0, 1);
    rd(1, 4'h1, 8'h41);
    rd(1, 4'h0, 8'h55);
    ack(8'h00, 24'h101042);
    rd(1, 4'h4, 8'h01);
    st(0, 1);

    tick(); tick();
    done = 1'b1;
    repeat (20) tick();
    $display("FAIL watchdog: monitor did not finish, want summary");
    $fatal(1, "watchdog");
  end
endmodule
